// File: rtl/gemm_job_scheduler.sv
// Round-robin job scheduler sharing one GEMM core among NUM_REQ requesters.
// Latches the winner's scalars, holds the core start handshake, and returns a done or timeout pulse.
module gemm_job_scheduler #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEL_W          = $clog2(NUM_REQ)
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [NUM_REQ-1:0]            ireq,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ialpha_flat,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ibeta_flat,
  input  logic                          icore_busy,
  input  logic                          icore_done,
  output logic                          ostart,
  output logic [DATA_WIDTH-1:0]         oalpha,
  output logic [DATA_WIDTH-1:0]         obeta,
  output logic                          ocore_rst,
  output logic [NUM_REQ-1:0]            ogrant,
  output logic [SEL_W-1:0]              osel,
  output logic [NUM_REQ-1:0]            oreq_done,
  output logic [NUM_REQ-1:0]            oreq_err,
  output logic                          obusy,
  output logic [15:0]                   ojob_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

  state_t                  r_state;
  logic [SEL_W-1:0]        r_ptr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_start;
  logic [DATA_WIDTH-1:0]   r_alpha;
  logic [DATA_WIDTH-1:0]   r_beta;
  logic                    r_core_rst;
  logic [NUM_REQ-1:0]      r_grant;
  logic [SEL_W-1:0]        r_sel;
  logic [NUM_REQ-1:0]      r_req_done;
  logic [NUM_REQ-1:0]      r_req_err;
  logic                    r_busy;
  logic [15:0]             r_job_count;

  state_t                  w_state_nxt;
  logic [SEL_W-1:0]        w_ptr_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_start_nxt;
  logic [DATA_WIDTH-1:0]   w_alpha_nxt;
  logic [DATA_WIDTH-1:0]   w_beta_nxt;
  logic                    w_core_rst_nxt;
  logic [NUM_REQ-1:0]      w_grant_nxt;
  logic [SEL_W-1:0]        w_sel_nxt;
  logic [NUM_REQ-1:0]      w_req_done_nxt;
  logic [NUM_REQ-1:0]      w_req_err_nxt;
  logic                    w_busy_nxt;
  logic [15:0]             w_job_count_nxt;

  logic                    w_found;
  logic [SEL_W-1:0]        w_win;
  logic [SEL_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_alpha_sel;
  logic [DATA_WIDTH-1:0]   w_beta_sel;
  logic [NUM_REQ-1:0]      w_win_oh;

  // Search upward from the requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (w_idx == SEL_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && ireq[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_alpha_sel = '0;
    w_beta_sel  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_win == SEL_W'(r)) begin
        w_alpha_sel = ialpha_flat[r*DATA_WIDTH +: DATA_WIDTH];
        w_beta_sel  = ibeta_flat[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

  // osel/oalpha/obeta default to holding so the operand mux stays stable while idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_start_nxt     = 1'b0;
    w_alpha_nxt     = r_alpha;
    w_beta_nxt      = r_beta;
    w_core_rst_nxt  = 1'b0;
    w_grant_nxt     = r_grant;
    w_sel_nxt       = r_sel;
    w_req_done_nxt  = '0;
    w_req_err_nxt   = '0;
    w_job_count_nxt = r_job_count;
    case (r_state)
      IDLE: begin
        if (w_found && !icore_done && !icore_busy) begin
          w_state_nxt = RUN;
          w_start_nxt = 1'b1;
          w_grant_nxt = w_win_oh;
          w_sel_nxt   = w_win;
          w_alpha_nxt = w_alpha_sel;
          w_beta_nxt  = w_beta_sel;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (icore_done) begin
          w_state_nxt     = DONE;
          w_start_nxt     = 1'b0;
          w_req_done_nxt  = r_grant;
          w_job_count_nxt = r_job_count + 16'd1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt    = ABORT;
          w_start_nxt    = 1'b0;
          w_core_rst_nxt = 1'b1;
          w_req_err_nxt  = r_grant;
        end
      end
      DONE, ABORT: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != IDLE);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state     <= IDLE;
      r_ptr       <= SEL_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_alpha     <= '0;
      r_beta      <= '0;
      r_core_rst  <= 1'b0;
      r_grant     <= '0;
      r_sel       <= '0;
      r_req_done  <= '0;
      r_req_err   <= '0;
      r_busy      <= 1'b0;
      r_job_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_start     <= w_start_nxt;
      r_alpha     <= w_alpha_nxt;
      r_beta      <= w_beta_nxt;
      r_core_rst  <= w_core_rst_nxt;
      r_grant     <= w_grant_nxt;
      r_sel       <= w_sel_nxt;
      r_req_done  <= w_req_done_nxt;
      r_req_err   <= w_req_err_nxt;
      r_busy      <= w_busy_nxt;
      r_job_count <= w_job_count_nxt;
    end
  end

  assign ostart     = r_start;
  assign oalpha     = r_alpha;
  assign obeta      = r_beta;
  assign ocore_rst  = r_core_rst;
  assign ogrant     = r_grant;
  assign osel       = r_sel;
  assign oreq_done  = r_req_done;
  assign oreq_err   = r_req_err;
  assign obusy      = r_busy;
  assign ojob_count = r_job_count;

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Bench for gemm_job_scheduler: a hand-computed vector table, directed corner sequences,
// and randomized traffic checked against a job-level reference model.
module tb_gemm_job_scheduler;

  localparam int DW = 64;
  localparam int NR = 4;
  localparam int TO = 8;
  localparam int SW = 2;

  logic             iclk = 1'b0;
  logic             irst;
  logic [NR-1:0]    ireq;
  logic [NR*DW-1:0] ialpha_flat;
  logic [NR*DW-1:0] ibeta_flat;
  logic             icore_busy;
  logic             icore_done;
  logic             ostart;
  logic [DW-1:0]    oalpha;
  logic [DW-1:0]    obeta;
  logic             ocore_rst;
  logic [NR-1:0]    ogrant;
  logic [SW-1:0]    osel;
  logic [NR-1:0]    oreq_done;
  logic [NR-1:0]    oreq_err;
  logic             obusy;
  logic [15:0]      ojob_count;

  gemm_job_scheduler #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .SEL_W(SW)
  ) dut (
    .iclk(iclk), .irst(irst), .ireq(ireq),
    .ialpha_flat(ialpha_flat), .ibeta_flat(ibeta_flat),
    .icore_busy(icore_busy), .icore_done(icore_done),
    .ostart(ostart), .oalpha(oalpha), .obeta(obeta), .ocore_rst(ocore_rst),
    .ogrant(ogrant), .osel(osel), .oreq_done(oreq_done), .oreq_err(oreq_err),
    .obusy(obusy), .ojob_count(ojob_count)
  );

  always #5 iclk = ~iclk;

  int nVec = 0;
  int nMis = 0;

  // Job-level reference: who owns the core, how many edges since the grant, and whether
  // the one-cycle wrap-up (done or error) is in progress.
  int            mOwner;
  int            mAge;
  int            mLast;
  bit            mFinish;
  logic [NR-1:0] eGrant, eDone, eErr;
  logic [SW-1:0] eSel;
  logic [DW-1:0] eAlpha, eBeta;
  logic          eStart, eCoreRst, eBusy;
  logic [15:0]   eCount;

  function automatic void modelReset();
    mOwner = -1; mAge = 0; mLast = NR - 1; mFinish = 1'b0;
    eGrant = '0; eDone = '0; eErr = '0; eSel = '0; eAlpha = '0; eBeta = '0;
    eStart = 1'b0; eCoreRst = 1'b0; eBusy = 1'b0; eCount = '0;
  endfunction

  function automatic void modelStep();
    eDone = '0; eErr = '0; eCoreRst = 1'b0;
    if (mFinish) begin
      mFinish = 1'b0; mOwner = -1; eGrant = '0; eBusy = 1'b0; eStart = 1'b0;
    end else if (mOwner < 0) begin
      if (ireq != '0 && !icore_done && !icore_busy) begin
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (mLast + k) % NR;
          if (mOwner < 0 && ireq[c[SW-1:0]]) mOwner = c;
        end
        mLast  = mOwner;
        mAge   = 0;
        eGrant = '0;
        eGrant[mOwner[SW-1:0]] = 1'b1;
        eSel   = mOwner[SW-1:0];
        eAlpha = ialpha_flat[mOwner*DW +: DW];
        eBeta  = ibeta_flat[mOwner*DW +: DW];
        eStart = 1'b1;
        eBusy  = 1'b1;
      end
    end else begin
      mAge++;
      if (icore_done) begin
        mFinish = 1'b1; eDone = eGrant; eCount = eCount + 16'd1; eStart = 1'b0;
      end else if (mAge == TO) begin
        mFinish = 1'b1; eErr = eGrant; eCoreRst = 1'b1; eStart = 1'b0;
      end
    end
  endfunction

  task automatic cmp(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp(tag, "ogrant",     64'(ogrant),     64'(eGrant));
    cmp(tag, "osel",       64'(osel),       64'(eSel));
    cmp(tag, "oalpha",     oalpha,          eAlpha);
    cmp(tag, "obeta",      obeta,           eBeta);
    cmp(tag, "ostart",     64'(ostart),     64'(eStart));
    cmp(tag, "ocore_rst",  64'(ocore_rst),  64'(eCoreRst));
    cmp(tag, "oreq_done",  64'(oreq_done),  64'(eDone));
    cmp(tag, "oreq_err",   64'(oreq_err),   64'(eErr));
    cmp(tag, "obusy",      64'(obusy),      64'(eBusy));
    cmp(tag, "ojob_count", 64'(ojob_count), 64'(eCount));
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, then wait for the next falling edge.
  task automatic applyStimulus(input logic [NR-1:0] req, input logic done, input logic busy);
    ireq = req; icore_done = done; icore_busy = busy;
    modelStep();
    @(negedge iclk);
  endtask

  task automatic step(input logic [NR-1:0] req, input logic done, input logic busy, input string tag);
    applyStimulus(req, done, busy);
    checkOutput(tag);
  endtask

  task automatic doReset();
    irst = 1'b1; ireq = '0; icore_done = 1'b0; icore_busy = 1'b0;
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic          done;
    logic          busy;
    logic [NR-1:0] grant;
    logic          start;
    logic          coreRst;
    logic [NR-1:0] rdone;
    logic [NR-1:0] rerr;
    logic          busyO;
    logic [15:0]   count;
    logic [63:0]   alpha;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [NR-1:0] req, logic d, logic b, logic [NR-1:0] g, logic s,
                              logic cr, logic [NR-1:0] rd, logic [NR-1:0] re, logic bo,
                              logic [15:0] cnt, logic [63:0] a);
    vec_t v;
    v.req = req; v.done = d; v.busy = b; v.grant = g; v.start = s; v.coreRst = cr;
    v.rdone = rd; v.rerr = re; v.busyO = bo; v.count = cnt; v.alpha = a;
    return v;
  endfunction

  int            doneTally[NR];
  logic [NR-1:0] fairOrder[5];

  initial begin
    for (int r = 0; r < NR; r++) begin
      ialpha_flat[r*DW +: DW] = 64'(2 + 16*r);
      ibeta_flat[r*DW +: DW]  = 64'(3 + 16*r);
    end
    // Single job, stale done, busy core, ignored mid-job request change, then a timeout.
    tbl[0]  = mk(4'b0001, 0, 0, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 0, 2);
    tbl[1]  = mk(4'b0001, 0, 0, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 0, 2);
    tbl[2]  = mk(4'b0001, 0, 0, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 0, 2);
    tbl[3]  = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 4'b0001, 4'b0000, 1, 1, 2);
    tbl[4]  = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 2);
    tbl[5]  = mk(4'b0010, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 2);
    tbl[6]  = mk(4'b0010, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 2);
    tbl[7]  = mk(4'b0010, 0, 0, 4'b0010, 1, 0, 4'b0000, 4'b0000, 1, 1, 18);
    tbl[8]  = mk(4'b0110, 1, 0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 2, 18);
    tbl[9]  = mk(4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 2, 18);
    tbl[10] = mk(4'b0100, 0, 0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 1, 2, 34);
    for (int i = 11; i <= 17; i++)
      tbl[i] = mk(4'b0100, 0, 0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 1, 2, 34);
    tbl[18] = mk(4'b0100, 0, 0, 4'b0100, 0, 1, 4'b0000, 4'b0100, 1, 2, 34);
    tbl[19] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 2, 34);

    @(negedge iclk);
    doReset();
    checkOutput("reset");

    for (int i = 0; i < 20; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      ireq = tbl[i].req; icore_done = tbl[i].done; icore_busy = tbl[i].busy;
      @(negedge iclk);
      cmp(t, "ogrant",     64'(ogrant),     64'(tbl[i].grant));
      cmp(t, "ostart",     64'(ostart),     64'(tbl[i].start));
      cmp(t, "ocore_rst",  64'(ocore_rst),  64'(tbl[i].coreRst));
      cmp(t, "oreq_done",  64'(oreq_done),  64'(tbl[i].rdone));
      cmp(t, "oreq_err",   64'(oreq_err),   64'(tbl[i].rerr));
      cmp(t, "obusy",      64'(obusy),      64'(tbl[i].busyO));
      cmp(t, "ojob_count", 64'(ojob_count), 64'(tbl[i].count));
      cmp(t, "oalpha",     oalpha,          tbl[i].alpha);
      cmp(t, "obeta",      obeta,           tbl[i].alpha + 64'd1);
    end

    // Fairness: all four requesting continuously, grants must rotate 0,1,2,3,0.
    doReset();
    fairOrder[0] = 4'b0001; fairOrder[1] = 4'b0010; fairOrder[2] = 4'b0100;
    fairOrder[3] = 4'b1000; fairOrder[4] = 4'b0001;
    for (int r = 0; r < NR; r++) doneTally[r] = 0;
    for (int j = 0; j < 5; j++) begin
      step(4'b1111, 0, 0, "fair");
      cmp("fair", $sformatf("order%0d", j), 64'(ogrant), 64'(fairOrder[j]));
      step(4'b1111, 0, 0, "fair");
      step(4'b1111, 1, 0, "fair");
      for (int r = 0; r < NR; r++) if (oreq_done[r]) doneTally[r]++;
      step(4'b1111, 0, 0, "fair");
    end
    cmp("fair", "tally0", 64'(doneTally[0]), 64'd2);
    for (int r = 1; r < NR; r++) cmp("fair", $sformatf("tally%0d", r), 64'(doneTally[r]), 64'd1);

    // Done arriving on the same edge the timeout would fire: done wins.
    step(4'b0100, 0, 0, "tedge");
    for (int k = 1; k < TO; k++) step(4'b0100, 0, 0, "tedge");
    step(4'b0100, 1, 0, "tedge");
    cmp("tedge", "done", 64'(oreq_done), 64'(4'b0100));
    cmp("tedge", "err",  64'(oreq_err),  64'd0);
    step(4'b0000, 0, 0, "tedge");

    // Asynchronous reset four cycles into a job, then requester 0 wins first.
    for (int k = 0; k < 4; k++) step(4'b1000, 0, 0, "rstmid");
    irst = 1'b1;
    #1;
    cmp("rstmid", "ogrant",     64'(ogrant),     64'd0);
    cmp("rstmid", "ostart",     64'(ostart),     64'd0);
    cmp("rstmid", "obusy",      64'(obusy),      64'd0);
    cmp("rstmid", "ojob_count", 64'(ojob_count), 64'd0);
    cmp("rstmid", "ocore_rst",  64'(ocore_rst),  64'd0);
    cmp("rstmid", "oalpha",     oalpha,          64'd0);
    modelReset();
    @(negedge iclk);
    irst = 1'b0;
    step(4'b1001, 0, 0, "rstmid");
    cmp("rstmid", "first", 64'(ogrant), 64'(4'b0001));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < NR; r++) begin
        ialpha_flat[r*DW +: DW] = {$urandom, $urandom};
        ibeta_flat[r*DW +: DW]  = {$urandom, $urandom};
      end
      step(NR'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #1000000;
    nMis++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
